// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and frame-length helper.
// The TX and RX stages both import this package.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    // Bit times per frame: start + data + optional parity + stop bits.
    function automatic int unsigned frame_len(input int unsigned width,
                                              input int unsigned parity,
                                              input int unsigned stop);
        return 32'd1 + width + ((parity != PARITY_NONE) ? 32'd1 : 32'd0) + stop;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Valid/ready byte handshake between user logic (master) and the UART TX serializer (slave).
interface uart_tx_serializer_if #(
    parameter int unsigned P_DATA_WIDTH = 8
);
    logic [P_DATA_WIDTH-1:0] i_user_tx_data;
    logic                    i_user_tx_valid;
    logic                    o_user_tx_ready;

    modport master (
        output i_user_tx_data,
        output i_user_tx_valid,
        input  o_user_tx_ready
    );

    modport slave (
        input  i_user_tx_data,
        input  i_user_tx_valid,
        output o_user_tx_ready
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one i_clk period is one bit time. Frames are
// start, data LSB first, optional parity, stop bits; back-to-back capable.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH  = 8,
    parameter int unsigned P_PARITY_TYPE = 0,
    parameter int unsigned P_STOP_WIDTH  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    uart_tx_serializer_if.slave   s_user,
    output logic                  o_uart_tx
);

    localparam int unsigned BIT_CNT_W  = $clog2(P_DATA_WIDTH);
    localparam int unsigned STOP_CNT_W = 1;
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT   = BIT_CNT_W'(P_DATA_WIDTH - 1);
    localparam logic [STOP_CNT_W-1:0] LAST_STOP  = STOP_CNT_W'(P_STOP_WIDTH - 1);
    localparam bit                    HAS_PARITY = (P_PARITY_TYPE != PARITY_NONE);

    if (P_DATA_WIDTH < 5 || P_DATA_WIDTH > 8) begin : g_bad_data_width
        $error("uart_tx_serializer: P_DATA_WIDTH must be 5..8");
    end
    if (P_PARITY_TYPE > PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_serializer: P_PARITY_TYPE must be 0, 1 or 2");
    end
    if (P_STOP_WIDTH != 1 && P_STOP_WIDTH != 2) begin : g_bad_stop
        $error("uart_tx_serializer: P_STOP_WIDTH must be 1 or 2");
    end

    uart_state_e              r_state;
    uart_state_e              w_state_nxt;
    logic [BIT_CNT_W-1:0]     r_bit_cnt;
    logic [BIT_CNT_W-1:0]     w_bit_cnt_nxt;
    logic [STOP_CNT_W-1:0]    r_stop_cnt;
    logic [STOP_CNT_W-1:0]    w_stop_cnt_nxt;
    logic [P_DATA_WIDTH-1:0]  r_shift;
    logic [P_DATA_WIDTH-1:0]  w_shift_nxt;
    logic                     r_parity;
    logic                     w_parity_nxt;
    logic                     r_ready;
    logic                     w_ready_nxt;
    logic                     r_tx;
    logic                     w_tx_nxt;
    logic                     w_fire;
    logic                     w_data_parity;

    assign w_fire        = s_user.i_user_tx_valid & r_ready;
    assign w_data_parity = (P_PARITY_TYPE == PARITY_ODD) ? ~(^s_user.i_user_tx_data)
                                                         :  (^s_user.i_user_tx_data);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next values of the counters, shifter and registered outputs.
    // The line value is derived from the current state, so it lags the state by one cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = '0;
        w_stop_cnt_nxt = '0;
        w_shift_nxt    = r_shift;
        w_parity_nxt   = r_parity;
        w_tx_nxt       = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_fire) begin
                    w_state_nxt  = ST_START;
                    w_shift_nxt  = s_user.i_user_tx_data;
                    w_parity_nxt = w_data_parity;
                end
            end
            ST_START: begin
                w_tx_nxt    = 1'b0;
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_tx_nxt    = r_shift[0];
                w_shift_nxt = r_shift >> 1;
                if (r_bit_cnt == LAST_BIT) begin
                    w_state_nxt = HAS_PARITY ? ST_PARITY : ST_STOP;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                end
            end
            ST_PARITY: begin
                w_tx_nxt    = r_parity;
                w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (r_stop_cnt == LAST_STOP) begin
                    if (w_fire) begin
                        w_state_nxt  = ST_START;
                        w_shift_nxt  = s_user.i_user_tx_data;
                        w_parity_nxt = w_data_parity;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_stop_cnt_nxt = r_stop_cnt + STOP_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Ready is aligned with the state it accepts in: idle, or the final stop cycle.
        w_ready_nxt = (w_state_nxt == ST_IDLE) ||
                      ((w_state_nxt == ST_STOP) && (w_stop_cnt_nxt == LAST_STOP));
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_ready    <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_ready    <= w_ready_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    assign s_user.o_user_tx_ready = r_ready;
    assign o_uart_tx              = r_tx;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations side by side, directed frame
// vectors and hand sequences, then random traffic against a frame-level reference model.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] data [4];
    logic [3:0] valid;
    logic [3:0] rdy;
    logic [3:0] tx;
    bit         chk_en;
    int         n_cmp;
    int         n_err;

    // Reference model state, updated on every rising edge.
    logic [31:0] m_pend [4];
    int          m_len  [4];
    int          m_left [4];
    logic [3:0]  m_line;
    logic [3:0]  m_rdy;

    typedef struct {
        int          idx;
        logic [7:0]  data;
        int          len;
        logic [15:0] bits;
    } vec_t;

    vec_t vecs [6];

    uart_tx_serializer_if #(.P_DATA_WIDTH(8)) if0 ();
    uart_tx_serializer_if #(.P_DATA_WIDTH(8)) if1 ();
    uart_tx_serializer_if #(.P_DATA_WIDTH(8)) if2 ();
    uart_tx_serializer_if #(.P_DATA_WIDTH(5)) if3 ();

    assign if0.i_user_tx_data  = data[0];
    assign if1.i_user_tx_data  = data[1];
    assign if2.i_user_tx_data  = data[2];
    assign if3.i_user_tx_data  = data[3][4:0];
    assign if0.i_user_tx_valid = valid[0];
    assign if1.i_user_tx_valid = valid[1];
    assign if2.i_user_tx_valid = valid[2];
    assign if3.i_user_tx_valid = valid[3];
    assign rdy[0] = if0.o_user_tx_ready;
    assign rdy[1] = if1.o_user_tx_ready;
    assign rdy[2] = if2.o_user_tx_ready;
    assign rdy[3] = if3.o_user_tx_ready;

    uart_tx_serializer #(.P_DATA_WIDTH(8), .P_PARITY_TYPE(0), .P_STOP_WIDTH(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .s_user(if0.slave), .o_uart_tx(tx[0]));
    uart_tx_serializer #(.P_DATA_WIDTH(8), .P_PARITY_TYPE(2), .P_STOP_WIDTH(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .s_user(if1.slave), .o_uart_tx(tx[1]));
    uart_tx_serializer #(.P_DATA_WIDTH(8), .P_PARITY_TYPE(1), .P_STOP_WIDTH(1)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .s_user(if2.slave), .o_uart_tx(tx[2]));
    uart_tx_serializer #(.P_DATA_WIDTH(5), .P_PARITY_TYPE(0), .P_STOP_WIDTH(2)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .s_user(if3.slave), .o_uart_tx(tx[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int cfg_w(input int i);
        return (i == 3) ? 5 : 8;
    endfunction

    function automatic int cfg_p(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction

    function automatic int cfg_s(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    // Whole frame in transmission order: bit k is the k-th bit on the line.
    function automatic logic [15:0] frame_bits(input int i, input logic [7:0] d);
        logic [15:0] f;
        int          ones;
        f    = '1;
        ones = 0;
        f[0] = 1'b0;
        for (int b = 0; b < cfg_w(i); b++) begin
            f[1 + b] = d[b];
            ones     = ones + int'(d[b]);
        end
        if (cfg_p(i) == 2) f[1 + cfg_w(i)] = ((ones % 2) == 1);
        if (cfg_p(i) == 1) f[1 + cfg_w(i)] = ((ones % 2) == 0);
        return f;
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // Reference model: a pending-bit schedule per DUT plus a busy countdown.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            int          flen;
            bit          hs;
            logic [15:0] fr;
            flen = int'(frame_len(32'(cfg_w(i)), 32'(cfg_p(i)), 32'(cfg_s(i))));
            if (rst) begin
                m_pend[i] = '1;
                m_len[i]  = 0;
                m_left[i] = 0;
                m_line[i] = 1'b1;
                m_rdy[i]  = 1'b0;
            end else begin
                hs = m_rdy[i] && valid[i];
                if (m_len[i] > 0) begin
                    m_line[i] = m_pend[i][0];
                    m_pend[i] = {1'b1, m_pend[i][31:1]};
                    m_len[i]  = m_len[i] - 1;
                end else begin
                    m_line[i] = 1'b1;
                end
                if (hs) begin
                    fr = frame_bits(i, data[i]);
                    for (int k = 0; k < flen; k++) m_pend[i][m_len[i] + k] = fr[k];
                    m_len[i]  = m_len[i] + flen;
                    m_left[i] = flen - 1;
                end else if (m_left[i] > 0) begin
                    m_left[i] = m_left[i] - 1;
                end
                m_rdy[i] = (m_left[i] == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("model_line%0d", i), tx[i], m_line[i]);
                chk($sformatf("model_ready%0d", i), rdy[i], m_rdy[i]);
            end
        end
    end

    // Sends one byte from idle and checks every line bit and ready against the vector.
    task automatic send_frame(input int idx, input logic [7:0] d, input int len,
                              input logic [15:0] bits, input string nm);
        @(negedge clk);
        data[idx]  = d;
        valid[idx] = 1'b1;
        @(negedge clk);
        valid[idx] = 1'b0;
        chk({nm, "_ready_start"}, rdy[idx], 1'b0);
        chk({nm, "_line_pre"}, tx[idx], 1'b1);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            chk($sformatf("%s_bit%0d", nm, k), tx[idx], bits[len - 1 - k]);
            chk($sformatf("%s_rdy%0d", nm, k), rdy[idx], (k >= len - 2));
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [19:0] bb;
        logic [9:0]  f0f;
        n_cmp  = 0;
        n_err  = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        valid  = '0;
        for (int i = 0; i < 4; i++) data[i] = '0;

        vecs[0] = '{0, 8'hA5, 10, 16'b0101001011};
        vecs[1] = '{1, 8'hA5, 11, 16'b01010010101};
        vecs[2] = '{2, 8'hA5, 11, 16'b01010010111};
        vecs[3] = '{1, 8'h01, 11, 16'b01000000011};
        vecs[4] = '{2, 8'h01, 11, 16'b01000000001};
        vecs[5] = '{3, 8'h15, 8,  16'b01010111};

        // Reset held for three edges, then released.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_en = 1'b1;
            chk($sformatf("rst_line%0d", c), tx[0], 1'b1);
            chk($sformatf("rst_ready%0d", c), rdy[0], 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", rdy[0], 1'b1);
        chk("line_after_release", tx[0], 1'b1);

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].idx, vecs[v].data, vecs[v].len, vecs[v].bits,
                       $sformatf("vec%0d", v));
        end

        // Back-to-back: valid held high, data changed while ready is low.
        bb = 20'b0000000001_0111111111;
        @(negedge clk);
        data[0]  = 8'h00;
        valid[0] = 1'b1;
        @(negedge clk);
        data[0]  = 8'hFF;
        chk("b2b_ready_start", rdy[0], 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 9) valid[0] = 1'b0;
            chk($sformatf("b2b_bit%0d", k), tx[0], bb[19 - k]);
            chk($sformatf("b2b_rdy%0d", k), rdy[0], (k == 8) || (k >= 18));
        end
        repeat (2) @(negedge clk);

        // Reset during data bit 3 of 0x0F aborts the frame.
        f0f = 10'b0111100001;
        @(negedge clk);
        data[0]  = 8'h0F;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("abort_bit%0d", k), tx[0], f0f[9 - k]);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_line_high", tx[0], 1'b1);
        chk("abort_ready_low", rdy[0], 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_release", rdy[0], 1'b1);
        chk("abort_line_idle", tx[0], 1'b1);
        send_frame(0, 8'h3C, 10, 16'b0001111001, "after_abort");

        // Random traffic on all configurations with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                data[i]  = 8'($urandom);
                valid[i] = ($urandom_range(0, 9) < 7);
            end
            rst = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        rst   = 1'b0;
        valid = '0;
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
